// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with NZCV flags and an iterative shift-add multiplier
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int AW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_MUL = 3'd6, OP_SHL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_result, r_mplier, w_b_eff, w_res;
    logic [2*WIDTH-1:0] r_mcand, r_prod, w_prod;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_flags;
    logic [WIDTH:0]     w_sum, w_shl;
    logic               w_accept, w_mul_done, w_c, w_v;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_HOLD && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_HOLD);
    assign result     = r_result;
    assign {flag_n, flag_z, flag_c, flag_v} = r_flags;

    // SUB shares the adder as a + ~b + 1
    assign w_b_eff    = (op == OP_SUB) ? ~b : b;
    assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, op == OP_SUB};
    assign w_shl      = {1'b0, a} << b[AW-1:0];
    assign w_prod     = r_mplier[0] ? r_prod + r_mcand : r_prod;
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(1));

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_ADD, OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = (op == OP_MUL) ? S_MUL : S_HOLD;
        else if (r_state == S_HOLD && out_ready)
            w_next = S_IDLE;
        else if (w_mul_done)
            w_next = S_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flags  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                if (op == OP_MUL) begin
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_prod   <= '0;
                    r_cnt    <= CW'(WIDTH);
                end else begin
                    r_result <= w_res;
                    r_flags  <= {w_res[WIDTH-1], w_res == '0, w_c, w_v};
                end
            end else if (r_state == S_MUL) begin
                r_prod   <= w_prod;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
                if (w_mul_done) begin
                    r_result <= w_prod[WIDTH-1:0];
                    r_flags  <= {w_prod[WIDTH-1], w_prod[WIDTH-1:0] == '0, |w_prod[2*WIDTH-1:WIDTH], 1'b0};
                end
            end
        end
    end
endmodule
